gbsha_fir_top: RTL and testbench

//   Chip-level wrapper around a direct-form FIR filter for an 8-in/8-out tile slot.
//   - Clock, reset and signed input samples arrive on io_in.
//   - The filtered, registered output leaves on io_out.
//   - Coefficients are compile-time parameters; no runtime programming path.

---
 rtl/gbsha_fir_pkg.sv | 25 ++
 rtl/gbsha_fir_core.sv | 86 ++++++++
 rtl/gbsha_fir_top.sv | 50 +++++
 tb/tb_gbsha_fir_top.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/gbsha_fir_pkg.sv
// Shared definitions for the gbsha FIR tile.
//   - Default parameter constants for the FIR (taps, widths, coefficients, shift).
//   - Signed sample / coefficient typedefs at the default widths.
//   - acc_width(): full-precision accumulator width for a given tap count and operand widths.
package gbsha_fir_pkg;

  localparam int unsigned DefNTaps  = 1;
  localparam int unsigned DefBwIn   = 2;
  localparam int unsigned DefBwOut  = 2;
  localparam int unsigned DefBwCoef = 4;
  localparam int unsigned DefShift  = 0;

  // Single tap of +1: a pure two-cycle pass-through.
  localparam logic [DefNTaps*DefBwCoef-1:0] DefCoefs = 4'b0001;

  typedef logic signed [DefBwIn-1:0]   sample_t;
  typedef logic signed [DefBwCoef-1:0] coef_t;

  // Sum of n_taps signed products of bw_in x bw_coef bits, with one guard bit.
  function automatic int unsigned acc_width(int unsigned n_taps, int unsigned bw_in,
                                            int unsigned bw_coef);
    return bw_in + bw_coef + $clog2(n_taps) + 1;
  endfunction

endpackage

// File: rtl/gbsha_fir_core.sv
// Direct-form FIR filter core.
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high; clears delay line and output register
//   x_in  in   BW_in-bit signed input sample, one consumed per clock
//   y_out out  BW_out-bit signed filtered sample (registered)
// Optional feature macro: FIR_SAT_EN (saturate instead of wrap when narrowing).
module gbsha_fir_core
  import gbsha_fir_pkg::*;
#(
  parameter int unsigned                     N_TAPS  = DefNTaps,
  parameter int unsigned                     BW_in   = DefBwIn,
  parameter int unsigned                     BW_out  = DefBwOut,
  parameter int unsigned                     BW_COEF = DefBwCoef,
  parameter logic [N_TAPS*BW_COEF-1:0]       COEFS   = DefCoefs,
  parameter int unsigned                     SHIFT   = DefShift
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [BW_in-1:0]  x_in,
  output logic signed [BW_out-1:0] y_out
);

  localparam int unsigned AccW = acc_width(N_TAPS, BW_in, BW_COEF);

  logic signed [BW_in-1:0]  x_d [N_TAPS];
  logic signed [AccW-1:0]   acc;
  logic signed [AccW-1:0]   s;
  logic signed [BW_out-1:0] y_d;
  logic signed [BW_out-1:0] y_q;

  // Delay line: x_d[0] is the newest sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < N_TAPS; k++) begin
        x_d[k] <= '0;
      end
    end else begin
      x_d[0] <= x_in;
      for (int unsigned k = 1; k < N_TAPS; k++) begin
        x_d[k] <= x_d[k-1];
      end
    end
  end

  // Full-precision MAC; operands are sign-extended to the accumulator width first.
  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < N_TAPS; k++) begin
      acc = acc + AccW'(x_d[k]) * AccW'($signed(COEFS[k*BW_COEF +: BW_COEF]));
    end
  end

  assign s = acc >>> SHIFT;

`ifdef FIR_SAT_EN
  localparam int SatMaxI = (1 << (BW_out - 1)) - 1;
  localparam int SatMinI = -(1 << (BW_out - 1));
  localparam logic signed [AccW-1:0] SatMax = AccW'(SatMaxI);
  localparam logic signed [AccW-1:0] SatMin = AccW'(SatMinI);

  always_comb begin
    y_d = BW_out'(s);
    if (s > SatMax) begin
      y_d = BW_out'(SatMax);
    end else if (s < SatMin) begin
      y_d = BW_out'(SatMin);
    end
  end
`else
  // Two's-complement wrap: keep the low BW_out bits.
  always_comb begin
    y_d = BW_out'(s);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/gbsha_fir_top.sv
// Tile-slot wrapper for the gbsha FIR filter (8 inputs / 8 outputs).
//   io_in[0]           clk
//   io_in[1]           rst, synchronous active-high
//   io_in[BW_in+1:2]   x_in, signed input sample
//   io_in[7:BW_in+2]   ignored
//   io_out[BW_out-1:0] y_out, filtered sample
//   io_out[7:BW_out]   tied to 0
// Power pins exist only in the gate-level netlist (GL_TEST); none here.
// Optional feature macro: FIR_SAT_EN (saturating narrowing inside the core).
module gbsha_fir_top
  import gbsha_fir_pkg::*;
#(
  parameter int unsigned               N_TAPS  = DefNTaps,
  parameter int unsigned               BW_in   = DefBwIn,
  parameter int unsigned               BW_out  = DefBwOut,
  parameter int unsigned               BW_COEF = DefBwCoef,
  parameter logic [N_TAPS*BW_COEF-1:0] COEFS   = DefCoefs,
  parameter int unsigned               SHIFT   = DefShift
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic signed [BW_out-1:0] y_out;

  gbsha_fir_core #(
    .N_TAPS  (N_TAPS),
    .BW_in   (BW_in),
    .BW_out  (BW_out),
    .BW_COEF (BW_COEF),
    .COEFS   (COEFS),
    .SHIFT   (SHIFT)
  ) u_core (
    .clk   (io_in[0]),
    .rst   (io_in[1]),
    .x_in  ($signed(io_in[BW_in+1:2])),
    .y_out (y_out)
  );

  always_comb begin
    io_out                = '0;
    io_out[BW_out-1:0]    = y_out;
  end

  if (BW_in + 2 < 8) begin : g_unused_in
    logic unused_in;
    assign unused_in = ^io_in[7:BW_in+2];
  end

endmodule

// File: tb/tb_gbsha_fir_top.sv
module tb_gbsha_fir_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] x   = 2'b00;
  logic [3:0] junk = 4'h0;
  logic [7:0] io_in;
  logic [7:0] out_def, out_step, out_ovf, out_mix;

  int n_assert = 0;
  int n_fail   = 0;

  // Input history, newest first; cleared by reset.
  int hist [8];
  logic [7:0] exp_def, exp_step, exp_ovf, exp_mix;

  assign io_in = {junk, x, rst, clk};

  always #5 clk = ~clk;

  // Defaults: 1 tap, h=1, BW_out=2.
  gbsha_fir_top u_def (.io_in(io_in), .io_out(out_def));

  gbsha_fir_top #(.N_TAPS(3), .BW_out(4), .COEFS(12'h111)) u_step (
    .io_in(io_in), .io_out(out_step));

  gbsha_fir_top #(.N_TAPS(3), .BW_out(2), .COEFS(12'h111)) u_ovf (
    .io_in(io_in), .io_out(out_ovf));

  // Taps h0..h3 = -3, 5, 2, -8; shift 1; 4-bit output overflows on some inputs.
  gbsha_fir_top #(.N_TAPS(4), .BW_out(4), .COEFS(16'h825D), .SHIFT(1)) u_mix (
    .io_in(io_in), .io_out(out_mix));

  function automatic logic [7:0] ref_y(int ntaps, int h[4], int shift, int bwout);
    int acc;
    int lo;
    int hi;
    acc = 0;
    lo  = -(1 << (bwout - 1));
    hi  = (1 << (bwout - 1)) - 1;
    for (int k = 0; k < ntaps; k++) acc += hist[k] * h[k];
    acc = acc >>> shift;
`ifdef FIR_SAT_EN
    if (acc > hi) acc = hi;
    if (acc < lo) acc = lo;
`endif
    return 8'(acc & ((1 << bwout) - 1));
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, update the reference at the edge, check all instances.
  task automatic step(logic r, int xs);
    @(negedge clk);
    rst  = r;
    x    = 2'(xs);
    junk = 4'($urandom_range(0, 15));
    @(posedge clk);
    if (r) begin
      exp_def = 8'h00; exp_step = 8'h00; exp_ovf = 8'h00; exp_mix = 8'h00;
      for (int k = 0; k < 8; k++) hist[k] = 0;
    end else begin
      exp_def  = ref_y(1, '{1, 0, 0, 0}, 0, 2);
      exp_step = ref_y(3, '{1, 1, 1, 0}, 0, 4);
      exp_ovf  = ref_y(3, '{1, 1, 1, 0}, 0, 2);
      exp_mix  = ref_y(4, '{-3, 5, 2, -8}, 1, 4);
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = xs;
    end
    #1;
    check("model_def", out_def, exp_def);
    check("model_step", out_step, exp_step);
    check("model_ovf", out_ovf, exp_ovf);
    check("model_mix", out_mix, exp_mix);
  endtask

  initial begin
    int seq_pt [6];
    logic [7:0] ramp [6];
    logic [7:0] ovf_steady;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    seq_pt = '{1, -1, -2, 0, 0, 0};
    ramp   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h03, 8'h03};
`ifdef FIR_SAT_EN
    ovf_steady = 8'h01;
`else
    ovf_steady = 8'h03;
`endif

    // Reset for two edges with x_in=01, then one released edge with x_in=0.
    step(1'b1, 1);
    step(1'b1, 1);
    check("reset_def", out_def, 8'h00);
    check("reset_mix", out_mix, 8'h00);
    step(1'b0, 0);
    check("post_reset_def", out_def, 8'h00);

    // Impulse through the default filter.
    step(1'b0, 1);
    check("impulse_e1", out_def, 8'h00);
    step(1'b0, 0);
    check("impulse_e2", out_def, 8'h01);
    step(1'b0, 0);
    check("impulse_e3", out_def, 8'h00);

    // Pass-through of 1, -1, -2, 0: output lags by two edges.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, seq_pt[i]);
      if (i >= 1) check($sformatf("pass_%0d", i), out_def, 8'(seq_pt[i-1] & 3));
    end

    // Flush, then step input into the 3-tap filter.
    for (int i = 0; i < 4; i++) step(1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1);
      check($sformatf("step_%0d", i), out_step, ramp[i]);
    end
    check("ovf_steady", out_ovf, ovf_steady);

    // Mid-stream reset erases history; ramp restarts.
    step(1'b1, 1);
    check("midrst_step", out_step, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1);
      check($sformatf("reramp_%0d", i), out_step, ramp[i]);
    end

    // Random samples with occasional resets.
    for (int i = 0; i < 400; i++) begin
      int xs;
      xs = int'($urandom_range(0, 3));
      if (xs >= 2) xs -= 4;
      step(($urandom_range(0, 29) == 0), xs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
